// File: rtl/seq_odd_squarer.sv
// Multi-cycle squarer: n*n as the running sum of the first n odd numbers.
// Optional sticky start-during-RUN flag: define SQUARER_ERROR_EN.
module seq_odd_squarer #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
`ifdef SQUARER_ERROR_EN
  output logic               error,
`endif
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [2*WIDTH:0]     odd_q, odd_d;
  logic [2*WIDTH-1:0]   sum_q, sum_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 accept;

  assign accept = enable && start &&
                  (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    odd_d    = odd_q;
    sum_d    = sum_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    if (enable) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            count_d = operand;
            sum_d   = '0;
            odd_d   = {{(2*WIDTH){1'b0}}, 1'b1};
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (count_q != '0) begin
            sum_d   = sum_q + odd_q[2*WIDTH-1:0];
            odd_d   = odd_q + {{(2*WIDTH-1){1'b0}}, 2'd2};
            count_d = count_q - 1'b1;
          end else begin
            result_d = sum_q;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
      // an accepted start wins over setting the flag
      if (state_q == RUN && start)
        err_d = 1'b1;
      if (accept)
        err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      odd_q    <= {{(2*WIDTH){1'b0}}, 1'b1};
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      odd_q    <= odd_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

`ifdef SQUARER_ERROR_EN
  assign error = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_seq_odd_squarer.sv
// Directed bench for seq_odd_squarer (WIDTH=8).
// Checks latency, results, back-to-back, stall and reset abort.
module tb_seq_odd_squarer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic [7:0]  operand;
  logic        busy;
  logic        done;
  logic [15:0] result;
`ifdef SQUARER_ERROR_EN
  logic        error;
`endif

  int n_cmp;
  int n_bad;

  seq_odd_squarer #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
`ifdef SQUARER_ERROR_EN
    .error   (error),
`endif
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts edges after the start edge until done; also busy samples.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (!done && cyc < 2000) begin
      if (busy) bc++;
      step();
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic kick(input logic [7:0] n);
    start   = 1'b1;
    operand = n;
    step();
    start   = 1'b0;
    operand = 8'hAA;
  endtask

  int cyc, bc;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    enable  = 1'b1;
    start   = 1'b0;
    operand = 8'd0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    step();

    kick(8'd5);
    wait_done(cyc, bc);
    chk("n5_lat", cyc, 6);
    chk("n5_busy", bc, 6);
    chk("n5_result", result, 25);
    chk("n5_busy_at_done", busy, 0);
    step();
    chk("n5_done_drop", done, 0);
    chk("n5_hold", result, 25);

    kick(8'd0);
    wait_done(cyc, bc);
    chk("n0_lat", cyc, 1);
    chk("n0_result", result, 0);
    step();

    kick(8'd255);
    wait_done(cyc, bc);
    chk("n255_lat", cyc, 256);
    chk("n255_result", result, 16'hFE01);
    step();

    // back-to-back: start held during the DONE cycle
    kick(8'd3);
    wait_done(cyc, bc);
    chk("b2b_lat1", cyc, 4);
    chk("b2b_res1", result, 9);
    kick(8'd4);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_res_held", result, 9);
    wait_done(cyc, bc);
    chk("b2b_lat2", cyc, 5);
    chk("b2b_res2", result, 16);
    step();

    // start during RUN is ignored
    kick(8'd6);
    step();
    start   = 1'b1;
    operand = 8'd2;
    step();
    start   = 1'b0;
`ifdef SQUARER_ERROR_EN
    chk("err_set", error, 1);
`endif
    wait_done(cyc, bc);
    chk("ign_lat", cyc + 2, 7);
    chk("ign_result", result, 36);
`ifdef SQUARER_ERROR_EN
    chk("err_sticky", error, 1);
`endif
    step();

    // stall mid-RUN
    kick(8'd7);
    repeat (3) step();
    enable = 1'b0;
    repeat (10) step();
    chk("stall_busy", busy, 1);
    chk("stall_done", done, 0);
    enable = 1'b1;
    wait_done(cyc, bc);
    chk("stall_rem", cyc + 3, 8);
    chk("stall_result", result, 49);
    enable = 1'b0;
    repeat (3) step();
    chk("stall_done_hold", done, 1);
    chk("stall_res_hold", result, 49);
    enable = 1'b1;
    step();
    chk("stall_done_drop", done, 0);

    // reset abort mid-RUN
    kick(8'd9);
`ifdef SQUARER_ERROR_EN
    chk("err_clear", error, 0);
`endif
    repeat (4) step();
    reset = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    #2 reset = 1'b1;
    step();
    kick(8'd2);
    wait_done(cyc, bc);
    chk("post_rst_lat", cyc, 3);
    chk("post_rst_result", result, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
